// File: rtl/r3_byte_unpack.sv
// Streaming R3 byte decoder: unpacks four value+1 encoded 2-bit fields per byte
// into {c1,c0} trits (00=0, 01=+1, 11=-1) with a valid/ready handshake on both sides.
module r3_byte_unpack #(
    parameter int P      = 761,
    parameter int NBYTES = 191,
    parameter int IDXW   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_c0,
    output logic            out_c1,
    output logic [IDXW-1:0] out_idx,
    output logic            busy,
    output logic            done,
    output logic            fmt_err
);

    localparam int BCW = $clog2(NBYTES + 1);
    // Field pointer value of the only/last used field in the final byte.
    localparam logic [1:0] LAST_FP = 2'((P - 1) % 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      buf_q, buf_d;
    logic            buf_valid_q, buf_valid_d;
    logic [1:0]      fp_q, fp_d;
    logic [BCW-1:0]  bytes_taken_q, bytes_taken_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            c0_q, c0_d;
    logic            c1_q, c1_d;
    logic            fmt_err_q, fmt_err_d;

    logic            out_fire;
    logic            in_fire;
    logic            last_byte;
    logic            final_field;
    logic            in_ready_int;
    logic [1:0]      cur_field;
    logic [1:0]      next_field;
    logic [1:0]      next_trit;
    logic [1:0]      load_trit;

    function automatic logic [1:0] field_of(input logic [7:0] b, input logic [1:0] sel);
        logic [1:0] f;
        case (sel)
            2'd0:    f = b[1:0];
            2'd1:    f = b[3:2];
            2'd2:    f = b[5:4];
            default: f = b[7:6];
        endcase
        return f;
    endfunction

    // Returns {c1,c0}; the invalid code 11 maps to zero and is flagged separately.
    function automatic logic [1:0] decode_field(input logic [1:0] f);
        logic [1:0] t;
        case (f)
            2'b00:   t = 2'b11;
            2'b01:   t = 2'b00;
            2'b10:   t = 2'b01;
            default: t = 2'b00;
        endcase
        return t;
    endfunction

    always_comb begin
        last_byte    = (bytes_taken_q == BCW'(NBYTES));
        final_field  = (fp_q == 2'd3) || (last_byte && (fp_q == LAST_FP));
        out_fire     = buf_valid_q && out_ready;
        in_ready_int = (state_q == S_RUN) && (bytes_taken_q < BCW'(NBYTES)) &&
                       (!buf_valid_q || (out_fire && final_field));
        in_fire      = in_valid && in_ready_int;
        cur_field    = field_of(buf_q, fp_q);
        next_field   = field_of(buf_q, fp_q + 2'd1);
        next_trit    = decode_field(next_field);
        load_trit    = decode_field(in_data[1:0]);
    end

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        buf_valid_d   = buf_valid_q;
        fp_d          = fp_q;
        bytes_taken_d = bytes_taken_q;
        out_idx_d     = out_idx_q;
        c0_d          = c0_q;
        c1_d          = c1_q;
        fmt_err_d     = fmt_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    buf_valid_d   = 1'b0;
                    fp_d          = '0;
                    bytes_taken_d = '0;
                    out_idx_d     = '0;
                    c0_d          = 1'b0;
                    c1_d          = 1'b0;
                    fmt_err_d     = 1'b0;
                end
            end

            S_RUN: begin
                if (out_fire) begin
                    out_idx_d = out_idx_q + 1'b1;
                    if (cur_field == 2'b11) begin
                        fmt_err_d = 1'b1;
                    end
                    if (final_field) begin
                        buf_valid_d = 1'b0;
                        fp_d        = '0;
                    end else begin
                        fp_d = fp_q + 2'd1;
                        c1_d = next_trit[1];
                        c0_d = next_trit[0];
                    end
                    if (out_idx_q == IDXW'(P - 1)) begin
                        state_d = S_DONE;
                    end
                end

                // A same-cycle load overrides the drain of the final field.
                if (in_fire) begin
                    buf_d         = in_data;
                    buf_valid_d   = 1'b1;
                    fp_d          = '0;
                    c1_d          = load_trit[1];
                    c0_d          = load_trit[0];
                    bytes_taken_d = bytes_taken_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            buf_q         <= '0;
            buf_valid_q   <= 1'b0;
            fp_q          <= '0;
            bytes_taken_q <= '0;
            out_idx_q     <= '0;
            c0_q          <= 1'b0;
            c1_q          <= 1'b0;
            fmt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            buf_valid_q   <= buf_valid_d;
            fp_q          <= fp_d;
            bytes_taken_q <= bytes_taken_d;
            out_idx_q     <= out_idx_d;
            c0_q          <= c0_d;
            c1_q          <= c1_d;
            fmt_err_q     <= fmt_err_d;
        end
    end

    assign in_ready  = in_ready_int;
    assign out_valid = buf_valid_q;
    assign out_c0    = c0_q;
    assign out_c1    = c1_q;
    assign out_idx   = out_idx_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_r3_byte_unpack.sv
// Directed bench for r3_byte_unpack: reset, single byte, full polynomials with
// stalls, ignored restart and mid-stream reset, checked against a software decode.
module tb_r3_byte_unpack;

    localparam int P      = 761;
    localparam int NBYTES = 191;
    localparam int IDXW   = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            out_c0;
    logic            out_c1;
    logic [IDXW-1:0] out_idx;
    logic            busy;
    logic            done;
    logic            fmt_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] bytes [NBYTES];

    r3_byte_unpack #(.P(P), .NBYTES(NBYTES), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c0(out_c0), .out_c1(out_c1), .out_idx(out_idx),
        .busy(busy), .done(done), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Software decode of one field into {c1,c0}.
    function automatic logic [1:0] dec(input logic [7:0] b, input int f);
        logic [7:0] s;
        s = b >> (2 * f);
        case (s[1:0])
            2'b00:   return 2'b11;
            2'b01:   return 2'b00;
            2'b10:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic exp_fmt();
        logic [7:0] s;
        for (int k = 0; k < P; k++) begin
            s = bytes[k / 4] >> (2 * (k % 4));
            if (s[1:0] == 2'b11) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_rst();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_valid_bytes();
        for (int i = 0; i < NBYTES; i++) begin
            bytes[i] = {2'($urandom_range(2)), 2'($urandom_range(2)),
                        2'($urandom_range(2)), 2'($urandom_range(2))};
        end
    endtask

    // Streams the current byte table through a running decoder, comparing every
    // accepted coefficient, stall stability and the completion pulse.
    task automatic drive_poly(input int in_pct, input int out_pct, input int start_at,
                              input int rst_at, output int span);
        int bi = 0, k = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
        bit stall = 1'b0, pulsed = 1'b0;
        logic [IDXW+1:0] held = '0;
        span = -1;
        while (k < P && cyc < 20000) begin
            if (rst_at >= 0 && k == rst_at) begin
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
            in_valid  = ($urandom_range(99) < in_pct);
            in_data   = (bi < NBYTES) ? bytes[bi] : 8'hA5;
            out_ready = ($urandom_range(99) < out_pct);
            start     = (start_at >= 0 && k == start_at && !pulsed);
            if (start) pulsed = 1'b1;
            #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL run_status k=%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
            end
            if (bi >= NBYTES) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL surplus_ready bytes=%0d in_ready=%b required 0", bi, in_ready);
                end
            end
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_c1, out_c0, out_idx} !== held) begin
                    errors++;
                    $display("FAIL stall_hold v=%b got=%h required=%h", out_valid,
                             {out_c1, out_c0, out_idx}, held);
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_c1, out_c0, out_idx};
            if (out_valid && out_ready) begin
                checks++;
                if (out_idx !== IDXW'(k) || {out_c1, out_c0} !== dec(bytes[k / 4], k % 4)) begin
                    errors++;
                    $display("FAIL coeff idx=%0d trit=%b required idx=%0d trit=%b", out_idx,
                             {out_c1, out_c0}, k, dec(bytes[k / 4], k % 4));
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                k++;
            end
            if (in_valid && in_ready) bi++;
            tick();
            cyc++;
        end
        start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        checks++;
        if (k < P) begin
            errors++;
            $display("FAIL timeout coefficients=%0d required %0d", k, P);
            return;
        end
        span = last_cyc - first_cyc;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b out_valid=%b required 1 0 0", done, busy, out_valid);
        end
        checks++;
        if (fmt_err !== exp_fmt()) begin
            errors++;
            $display("FAIL fmt_err_final got=%b required %b", fmt_err, exp_fmt());
        end
        tick();
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL after_done done=%b busy=%b in_ready=%b required 0 0 0", done, busy, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
            #1;
            checks++;
            if ({in_ready, out_valid, busy, done, fmt_err, out_c0, out_c1, out_idx} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d rdy=%b v=%b busy=%b done=%b err=%b idx=%0d required all 0",
                         i, in_ready, out_valid, busy, done, fmt_err, out_idx);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single_byte();
        logic [1:0] exp_t [4] = '{2'b11, 2'b00, 2'b01, 2'b00};
        do_rst();
        do_start();
        in_valid = 1'b1; in_data = 8'hE4; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_accept in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_idx !== IDXW'(i) || {out_c1, out_c0} !== exp_t[i] ||
                fmt_err !== 1'b0) begin
                errors++;
                $display("FAIL e4_coeff v=%b idx=%0d trit=%b err=%b required 1 %0d %b 0",
                         out_valid, out_idx, {out_c1, out_c0}, fmt_err, i, exp_t[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (fmt_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL e4_fmt_err fmt_err=%b out_valid=%b required 1 0", fmt_err, out_valid);
        end
        tick();
    endtask

    task automatic test_full_poly();
        int span;
        for (int i = 0; i < NBYTES - 1; i++) bytes[i] = 8'h55;
        bytes[NBYTES - 1] = 8'hFD;
        do_rst();
        do_start();
        #1;
        checks++;
        if (busy !== 1'b1 || fmt_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_state busy=%b fmt_err=%b out_valid=%b required 1 0 0", busy, fmt_err, out_valid);
        end
        drive_poly(100, 100, -1, -1, span);
        checks++;
        if (span !== P - 1) begin
            errors++;
            $display("FAIL full_no_bubble span=%0d required %0d", span, P - 1);
        end
    endtask

    task automatic test_random_stalls();
        int span;
        for (int i = 0; i < NBYTES; i++) bytes[i] = 8'($urandom_range(255));
        do_rst();
        do_start();
        drive_poly(70, 50, -1, -1, span);
    endtask

    task automatic test_back_to_back_restart();
        int span;
        fill_valid_bytes();
        do_rst();
        do_start();
        drive_poly(100, 100, 300, -1, span);
        checks++;
        if (span !== P - 1) begin
            errors++;
            $display("FAIL restart_ignored span=%0d required %0d", span, P - 1);
        end
    endtask

    task automatic test_rst_mid();
        int span;
        fill_valid_bytes();
        bytes[0] = 8'hFF;
        do_rst();
        do_start();
        drive_poly(100, 60, -1, 400, span);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, done, fmt_err, out_c0, out_c1, out_idx} !== '0) begin
            errors++;
            $display("FAIL rst_mid rdy=%b v=%b busy=%b done=%b err=%b idx=%0d required all 0",
                     in_ready, out_valid, busy, done, fmt_err, out_idx);
        end
        fill_valid_bytes();
        do_start();
        #1;
        checks++;
        if (busy !== 1'b1 || fmt_err !== 1'b0 || out_idx !== '0) begin
            errors++;
            $display("FAIL restart_clean busy=%b fmt_err=%b idx=%0d required 1 0 0", busy, fmt_err, out_idx);
        end
        drive_poly(100, 100, -1, -1, span);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_full_poly();
        test_random_stalls();
        test_back_to_back_restart();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
